// File: rtl/inst_queue.sv
// ---------------------------------------------------------------------------
// inst_queue
//
// Instruction fetch queue sitting between the fetch stage and the decoder of
// the Tomasulo pipeline. Fetched (pc, inst) pairs are buffered in a circular
// FIFO so fetch can keep running while decode/issue is stalled. A branch
// redirect (flush) discards every buffered entry.
//
// Parameters:
//   DEPTH   number of entries (power of two, >= 2)
//   ADDR_W  pointer width, must equal log2(DEPTH)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   flush      in   branch redirect, empties the queue at the next edge
//   in_valid   in   fetch presents an instruction
//   in_ready   out  queue can accept an instruction this cycle
//   in_pc      in   pc of the fetched instruction
//   in_inst    in   fetched instruction word
//   out_valid  out  head entry valid for the decoder
//   out_ready  in   decoder consumes the head this cycle
//   out_pc     out  pc of the head entry (0 when empty)
//   out_inst   out  instruction of the head entry (0 when empty)
//   count      out  number of occupied entries, 0..DEPTH
//
// Build option:
//   INST_QUEUE_BYPASS_EN  when defined, an instruction offered to an empty
//                         queue is presented combinationally on out_*; if the
//                         decoder takes it in that cycle it is never stored.
// ---------------------------------------------------------------------------
module inst_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_inst,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [31:0]       r_pcMem   [DEPTH];
    logic [31:0]       r_instMem [DEPTH];
    logic [ADDR_W-1:0] r_wrPtr;
    logic [ADDR_W-1:0] r_rdPtr;
    logic [ADDR_W:0]   r_cnt;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_bypass;

    assign w_empty  = (r_cnt == '0);
    assign w_full   = (r_cnt == FULL_CNT);
    assign in_ready = !w_full && !flush;
    assign count    = r_cnt;

`ifdef INST_QUEUE_BYPASS_EN
    // An empty queue forwards the fetch side straight to the decoder; when
    // the decoder accepts, the instruction is consumed without being stored.
    assign w_bypass  = w_empty && !flush && in_valid && out_ready;
    assign out_valid = w_empty ? (in_valid && !flush) : !flush;
`else
    assign w_bypass  = 1'b0;
    assign out_valid = !w_empty && !flush;
`endif

    // A pop only ever removes a stored entry; a bypassed instruction is
    // handled by suppressing the push instead.
    assign w_push = in_valid && in_ready && !w_bypass;
    assign w_pop  = out_valid && out_ready && !w_empty;

    // Head data is forced to zero when nothing is stored so stale array
    // contents never leak onto the decoder bus.
    always_comb begin
        out_pc   = '0;
        out_inst = '0;
        if (!w_empty) begin
            out_pc   = r_pcMem[r_rdPtr];
            out_inst = r_instMem[r_rdPtr];
        end
`ifdef INST_QUEUE_BYPASS_EN
        else if (!flush) begin
            out_pc   = in_pc;
            out_inst = in_inst;
        end
`endif
    end

    // Storage arrays carry no reset; only pointers and occupancy define
    // which slots hold live data.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pcMem[r_wrPtr]   <= in_pc;
            r_instMem[r_wrPtr] <= in_inst;
        end
    end

    // Pointers wrap naturally because their width is exactly log2(DEPTH).
    // Flush overrides any handshake, although in_ready/out_valid are
    // already low during a flush cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_cnt   <= '0;
        end else if (flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_ONE;
                2'b01:   r_cnt <= r_cnt - CNT_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// ---------------------------------------------------------------------------
// tb_inst_queue
//
// Self-checking bench for inst_queue. A queue of {pc, inst} pairs serves as
// the reference model; each scenario task drives inputs just after a rising
// edge, compares DUT outputs at the falling edge, then lets the model apply
// the same handshake rules before the next edge.
// ---------------------------------------------------------------------------
module tb_inst_queue;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_pc;
    logic [31:0]       in_inst;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_pc;
    logic [31:0]       out_inst;
    logic [ADDR_W:0]   count;

    int passCount  = 0;
    int checkCount = 0;

    logic [63:0] modelQ [$];
    logic [69:0] gotV;
    logic [69:0] expV;

    inst_queue #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {out_valid, in_ready, count, out_pc, out_inst} from the model
    // and the current inputs.
    function automatic logic [69:0] modelVec();
        int          sz;
        logic        v;
        logic        r;
        logic [31:0] p;
        logic [31:0] n;
        sz = modelQ.size();
        v  = (sz != 0) && !flush;
        r  = (sz != DEPTH) && !flush;
        p  = 32'd0;
        n  = 32'd0;
        if (sz != 0) begin
            p = modelQ[0][63:32];
            n = modelQ[0][31:0];
        end
`ifdef INST_QUEUE_BYPASS_EN
        if (sz == 0 && !flush) begin
            v = in_valid;
            p = in_pc;
            n = in_inst;
        end
`endif
        return {v, r, 4'(sz), p, n};
    endfunction

    // Applies the queue rules to the model for the current inputs, then
    // moves to just after the next rising edge.
    task automatic advance();
        int          sz;
        bit          doPush;
        bit          doPop;
        bit          bypass;
        logic [63:0] dropped;
        sz     = modelQ.size();
        bypass = 1'b0;
        if (flush) begin
            modelQ.delete();
        end else begin
`ifdef INST_QUEUE_BYPASS_EN
            bypass = (sz == 0) && in_valid && out_ready;
`endif
            doPop  = (sz != 0) && out_ready;
            doPush = in_valid && (sz != DEPTH) && !bypass;
            if (doPop) begin
                dropped = modelQ.pop_front();
            end
            if (doPush) begin
                modelQ.push_back({in_pc, in_inst});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_pc     = 32'd0;
        in_inst   = 32'd0;
        modelQ.delete();
        repeat (2) @(posedge clk);
        #1;
        #4;
        checkCount++;
        gotV = {out_valid, in_ready, count, out_pc, out_inst};
        expV = {1'b0, 1'b1, 4'd0, 32'd0, 32'd0};
        if (gotV !== expV) begin
            $display("[TB] FAIL reset_state: got %h required %h", gotV, expV);
        end else begin
            passCount++;
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH + 1; i++) begin
            in_valid  = 1'b1;
            out_ready = 1'b0;
            in_pc     = 32'(i * 4);
            in_inst   = 32'h1000 + 32'(i);
            #4;
            checkCount++;
            gotV = {out_valid, in_ready, count, out_pc, out_inst};
            expV = modelVec();
            if (gotV !== expV) begin
                $display("[TB] FAIL fill_%0d: got %h required %h", i, gotV, expV);
            end else begin
                passCount++;
            end
            advance();
        end
        in_valid = 1'b0;
        #4;
        checkCount++;
        if (count !== 4'd8 || in_ready !== 1'b0) begin
            $display("[TB] FAIL full_state: got count=%0d in_ready=%b required count=8 in_ready=0",
                     count, in_ready);
        end else begin
            passCount++;
        end
        advance();
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #4;
            checkCount++;
            if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_inst !== 32'h1000 + 32'(i)) begin
                $display("[TB] FAIL drain_%0d: got v=%b pc=%h inst=%h required v=1 pc=%h inst=%h",
                         i, out_valid, out_pc, out_inst, 32'(i * 4), 32'h1000 + 32'(i));
            end else begin
                passCount++;
            end
            advance();
        end
        #4;
        checkCount++;
        if (out_valid !== 1'b0 || count !== 4'd0) begin
            $display("[TB] FAIL drained_empty: got v=%b count=%0d required v=0 count=0",
                     out_valid, count);
        end else begin
            passCount++;
        end
        out_ready = 1'b0;
        advance();
    endtask

    task automatic test_stream_wrap();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'h300 + 32'(i * 4);
            in_inst  = $urandom;
            advance();
        end
        for (int i = 0; i < 20; i++) begin
            in_valid  = 1'b1;
            out_ready = 1'b1;
            in_pc     = $urandom;
            in_inst   = $urandom;
            #4;
            checkCount++;
            gotV = {out_valid, in_ready, count, out_pc, out_inst};
            expV = modelVec();
            if (gotV !== expV || count !== 4'd3) begin
                $display("[TB] FAIL stream_%0d: got %h required %h (count 3)", i, gotV, expV);
            end else begin
                passCount++;
            end
            advance();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #4;
            checkCount++;
            gotV = {out_valid, in_ready, count, out_pc, out_inst};
            expV = modelVec();
            if (gotV !== expV) begin
                $display("[TB] FAIL stream_drain_%0d: got %h required %h", i, gotV, expV);
            end else begin
                passCount++;
            end
            advance();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'h200 + 32'(i * 4);
            in_inst  = $urandom;
            advance();
        end
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h40;
        out_ready = 1'b1;
        #4;
        checkCount++;
        if (count !== 4'd5 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            $display("[TB] FAIL flush_cycle: got count=%0d in_ready=%b v=%b required 5 0 0",
                     count, in_ready, out_valid);
        end else begin
            passCount++;
        end
        advance();
        flush     = 1'b0;
        out_ready = 1'b0;
        in_pc     = 32'h80;
        in_inst   = 32'hCAFE0080;
        #4;
        checkCount++;
        if (count !== 4'd0 || in_ready !== 1'b1) begin
            $display("[TB] FAIL after_flush: got count=%0d in_ready=%b required 0 1", count, in_ready);
        end else begin
            passCount++;
        end
        advance();
        in_valid = 1'b0;
        #4;
        checkCount++;
        if (out_pc !== 32'h80 || out_inst !== 32'hCAFE0080 || count !== 4'd1) begin
            $display("[TB] FAIL post_flush_head: got pc=%h inst=%h count=%0d required 80 cafe0080 1",
                     out_pc, out_inst, count);
        end else begin
            passCount++;
        end
        advance();
        for (int i = 0; i < 3; i++) begin
            flush    = 1'b1;
            in_valid = 1'b1;
            in_pc    = $urandom;
            #4;
            checkCount++;
            gotV = {out_valid, in_ready, count, out_pc, out_inst};
            expV = modelVec();
            if (gotV !== expV) begin
                $display("[TB] FAIL held_flush_%0d: got %h required %h", i, gotV, expV);
            end else begin
                passCount++;
            end
            advance();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        #4;
        checkCount++;
        if (count !== 4'd0 || out_valid !== 1'b0) begin
            $display("[TB] FAIL held_flush_empty: got count=%0d v=%b required 0 0", count, out_valid);
        end else begin
            passCount++;
        end
        advance();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'h500 + 32'(i * 4);
            in_inst  = $urandom;
            advance();
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        modelQ.delete();
        #1;
        checkCount++;
        if (out_valid !== 1'b0 || count !== 4'd0) begin
            $display("[TB] FAIL async_reset: got v=%b count=%0d required 0 0", out_valid, count);
        end else begin
            passCount++;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        #4;
        checkCount++;
        gotV = {out_valid, in_ready, count, out_pc, out_inst};
        expV = modelVec();
        if (gotV !== expV) begin
            $display("[TB] FAIL after_async_reset: got %h required %h", gotV, expV);
        end else begin
            passCount++;
        end
        advance();
    endtask

    task automatic test_bypass();
        in_valid  = 1'b1;
        in_pc     = 32'h100;
        in_inst   = 32'hABCD0100;
        out_ready = 1'b1;
        #4;
        checkCount++;
`ifdef INST_QUEUE_BYPASS_EN
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || count !== 4'd0) begin
            $display("[TB] FAIL bypass_same_cycle: got v=%b pc=%h count=%0d required 1 100 0",
                     out_valid, out_pc, count);
        end else begin
            passCount++;
        end
        advance();
        in_valid = 1'b0;
        #4;
        checkCount++;
        if (count !== 4'd0 || out_valid !== 1'b0) begin
            $display("[TB] FAIL bypass_not_stored: got count=%0d v=%b required 0 0", count, out_valid);
        end else begin
            passCount++;
        end
`else
        if (out_valid !== 1'b0 || out_pc !== 32'd0) begin
            $display("[TB] FAIL no_bypass_same_cycle: got v=%b pc=%h required 0 0", out_valid, out_pc);
        end else begin
            passCount++;
        end
        advance();
        in_valid = 1'b0;
        #4;
        checkCount++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || count !== 4'd1) begin
            $display("[TB] FAIL no_bypass_next_cycle: got v=%b pc=%h count=%0d required 1 100 1",
                     out_valid, out_pc, count);
        end else begin
            passCount++;
        end
`endif
        advance();
        out_ready = 1'b0;
        #4;
        checkCount++;
        if (count !== 4'd0) begin
            $display("[TB] FAIL bypass_final_empty: got count=%0d required 0", count);
        end else begin
            passCount++;
        end
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (i < 200) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) == 0);
            end else begin
                in_valid  = ($urandom_range(0, 3) == 0);
                out_ready = ($urandom_range(0, 3) != 0);
            end
            flush   = ($urandom_range(0, 39) == 0);
            in_pc   = $urandom;
            in_inst = $urandom;
            #4;
            checkCount++;
            gotV = {out_valid, in_ready, count, out_pc, out_inst};
            expV = modelVec();
            if (gotV !== expV) begin
                $display("[TB] FAIL random_%0d: got %h required %h", i, gotV, expV);
            end else begin
                passCount++;
            end
            advance();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_fill_drain();
        test_stream_wrap();
        test_flush();
        test_async_reset();
        test_bypass();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Instruction fetch queue between the fetch stage and the decoder in the Tomasulo pipeline.
- Buffers fetched (pc, inst) pairs in a circular FIFO so fetch keeps running while decode/issue stalls on full reservation stations.
- Flushed on a branch redirect.
- Valid/ready handshake on both sides.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- ADDR_W, 3, pointer index width; must equal log2(DEPTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  branch redirect; discards all entries.
- in_valid  input  1  fetch stage presents a valid instruction.
- in_ready  output  1  queue accepts an entry this cycle.
- in_pc  input  32  pc of the fetched instruction.
- in_inst  input  32  fetched instruction word.
- out_valid  output  1  head entry valid for the decoder.
- out_ready  input  1  decoder consumes the head this cycle.
- out_pc  output  32  pc of the head entry.
- out_inst  output  32  instruction of the head entry.
- count  output  ADDR_W+1  number of occupied entries, 0..DEPTH.

Behaviour:
- Storage:
  - Two register arrays, pc_mem and inst_mem, each DEPTH x 32.
  - wr_ptr and rd_ptr, ADDR_W bits each; both wrap modulo DEPTH.
  - Occupancy register cnt, ADDR_W+1 bits.
- Reset (rst_n low, asynchronous):
  - wr_ptr=0, rd_ptr=0, cnt=0.
  - Therefore out_valid=0, in_ready=1, count=0.
  - out_pc=0 and out_inst=0 while empty.
  - Array contents are not reset.
- Outputs (combinational from state; no input-to-output path unless the bypass feature is enabled):
  - in_ready = (cnt != DEPTH) and not flush.
  - out_valid = (cnt != 0) and not flush.
  - out_pc / out_inst = pc_mem[rd_ptr] / inst_mem[rd_ptr] when cnt != 0, else 0.
  - count = cnt.
- Handshakes:
  - push = in_valid and in_ready: writes in_pc/in_inst at wr_ptr; wr_ptr increments.
  - pop = out_valid and out_ready: rd_ptr increments.
  - Occupancy update:
    - push only: cnt+1.
    - pop only: cnt-1.
    - both: cnt unchanged, both pointers advance.
- Latency: an entry pushed at edge N is visible on out_* in cycle N+1 (one cycle).
- Full (cnt==DEPTH):
  - in_ready=0; in_valid is ignored.
  - A pop in the same cycle does not allow a same-cycle push; the freed slot is available next cycle.
- Empty (cnt==0):
  - out_valid=0; out_ready is ignored.
  - A simultaneous push is stored normally.
- Wrap-around: pointer increment from DEPTH-1 returns to 0; no loss or duplication across the wrap.
- Flush (synchronous, highest priority below reset):
  - During the flush cycle, in_ready=0 and out_valid=0, so no push or pop occurs.
  - At the next edge wr_ptr=rd_ptr=0 and cnt=0.
  - Flush held for multiple cycles keeps the queue empty.
  - The first push is accepted in the cycle after flush deasserts.
- Reset mid-operation: state returns to reset values immediately, regardless of in-flight handshakes.
- Ordering: strict FIFO; entries leave in push order.

Optional Feature:
- Macro: INST_QUEUE_BYPASS_EN.
- Defined:
  - When cnt==0 and flush=0: out_valid=in_valid, out_pc=in_pc, out_inst=in_inst.
  - If out_ready=1 in that cycle, the instruction passes straight through, nothing is written, and pointers and cnt are unchanged (zero-cycle latency).
  - If out_ready=0, the entry is pushed normally.
  - in_ready is unchanged.
- Undefined:
  - No combinational in-to-out path; one-cycle minimum latency as described above.

Test Plan:
- Reset then idle:
  - rst_n=0 for 2 cycles -> out_valid=0, in_ready=1, count=0, out_pc=0, out_inst=0.
- Fill to full, then drain:
  - Push 8 entries, pc=0x00..0x1C, inst=0x1000+i, with out_ready=0 -> count=8, in_ready=0; a 9th push (pc=0x20) is ignored.
  - Then out_ready=1 -> 8 pops in order 0x00..0x1C; count returns to 0; out_valid drops.
- Steady stream across wrap:
  - Continuous push+pop for 20 cycles at count=3 -> count stays 3; pcs emerge in order with no gaps across the pointer wrap.
- Flush while partially full:
  - count=5, assert flush for 1 cycle with in_valid=1, pc=0x40 -> no push during the flush cycle; count=0 the next cycle.
  - Push pc=0x80 after flush -> that is the next out_pc.
- Async reset mid-stream:
  - count=4, drop rst_n between edges -> out_valid=0 and count=0 immediately, without waiting for a clock edge.
- Bypass (INST_QUEUE_BYPASS_EN defined):
  - Empty queue, in_valid=1, pc=0x100, out_ready=1 -> out_valid=1, out_pc=0x100 in the same cycle; count stays 0.
  - Without the macro: out_valid=0 in that cycle; out_pc=0x100 appears one cycle later.
